// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal TX FIFO and a valid/ready byte input.
// Frame format (data bits, parity, stop bits) and baud divider are fixed at elaboration.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  input  logic [DATA_BITS-1:0]          i_data,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);
  localparam int DIVIDER = CLK_FREQ / BAUD_RATE;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int DW      = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
  localparam int BW      = $clog2(DATA_BITS);

  if (DIVIDER < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx_fifo: illegal parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 push, pop;

  state_t               state;
  logic [DW-1:0]        baud;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift, sr;
  logic                 baud_end, stop_last, frame_end, par_bit;

  assign o_ready   = (o_count != CW'(FIFO_DEPTH));
  assign push      = i_valid && o_ready;
  assign baud_end  = (baud == DW'(DIVIDER - 1));
  assign stop_last = (stop_idx == 1'(STOP_BITS - 1));
  assign frame_end = (state == S_STOP) && baud_end && stop_last;
  assign pop       = (o_count != '0) && ((state == S_IDLE) || frame_end);
  // shift keeps the untouched word for parity; sr is the working shifter
  assign par_bit   = (PARITY == 1) ? ~^shift : ^shift;
  assign o_busy    = (state != S_IDLE) || (o_count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      o_count <= o_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      sr       <= '0;
      o_tx     <= 1'b1;
      o_done   <= 1'b0;
    end else begin
      // registered pulse lands on the last cycle of the last stop bit
      o_done <= (state == S_STOP) && stop_last && (baud == DW'(DIVIDER - 2));
      baud   <= baud_end ? '0 : baud + 1'b1;
      case (state)
        S_IDLE: begin
          baud <= '0;
          o_tx <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            sr      <= mem[rd_ptr];
            bit_idx <= '0;
            state   <= S_START;
            o_tx    <= 1'b0;
          end
        end
        S_START: if (baud_end) begin
          state <= S_DATA;
          o_tx  <= sr[0];
        end
        S_DATA: if (baud_end) begin
          if (bit_idx == BW'(DATA_BITS - 1)) begin
            stop_idx <= 1'b0;
            if (PARITY != 0) begin
              state <= S_PARITY;
              o_tx  <= par_bit;
            end else begin
              state <= S_STOP;
              o_tx  <= 1'b1;
            end
          end else begin
            bit_idx <= bit_idx + 1'b1;
            sr      <= sr >> 1;
            o_tx    <= sr[1];
          end
        end
        S_PARITY: if (baud_end) begin
          state    <= S_STOP;
          stop_idx <= 1'b0;
          o_tx     <= 1'b1;
        end
        S_STOP: if (baud_end) begin
          if (!stop_last) begin
            stop_idx <= 1'b1;
          end else if (pop) begin
            shift   <= mem[rd_ptr];
            sr      <= mem[rd_ptr];
            bit_idx <= '0;
            state   <= S_START;
            o_tx    <= 1'b0;
          end else begin
            state <= S_IDLE;
            o_tx  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          o_tx  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: drivers queue expected frames, per-DUT line monitors decode o_tx and compare.
module tb_uart_tx_fifo;
  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] vld, rdy, tx_w, busy_w, done_w;
  logic [8:0] dat [3];
  logic [2:0] cnt0;
  logic [4:0] cnt1, cnt2;

  int total = 0, bad = 0, cyc = 0, last_acc = 0;
  int DB[3]  = '{8, 7, 7};
  int PAR[3] = '{0, 2, 1};
  int STB[3] = '{1, 2, 2};
  logic [9:0] expq [3][$];
  int frames[3] = '{0, 0, 0};
  int dones[3]  = '{0, 0, 0};
  int nst[3]    = '{0, 0, 0};
  int st[3][64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst) for (int i = 0; i < 3; i++) dones[i] <= dones[i] + int'(done_w[i]);

  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .i_valid(vld[0]), .i_data(dat[0][7:0]), .o_ready(rdy[0]),
    .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_done(done_w[0]), .o_count(cnt0));
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(16)) u1 (
    .clk(clk), .rst(rst), .i_valid(vld[1]), .i_data(dat[1][6:0]), .o_ready(rdy[1]),
    .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_done(done_w[1]), .o_count(cnt1));
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(16)) u2 (
    .clk(clk), .rst(rst), .i_valid(vld[2]), .i_data(dat[2][6:0]), .o_ready(rdy[2]),
    .o_tx(tx_w[2]), .o_busy(busy_w[2]), .o_done(done_w[2]), .o_count(cnt2));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // entry holds {parity bit, data}; queued at issue, checked when the frame appears
  task automatic push(input int id, input logic [8:0] d, input logic p);
    int n = 0;
    logic acc;
    vld[id] = 1'b1;
    dat[id] = d;
    expq[id].push_back({p, d});
    do begin
      acc = rdy[id];
      last_acc = cyc;
      step();
      n++;
    end while (!acc && n < 3000);
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_frames(input int id, input int n);
    int k = 0;
    while (frames[id] < n && k < 3000) begin
      step();
      k++;
    end
    chk($sformatf("frames%0d", id), frames[id], n);
  endtask

  task automatic mon(input int id);
    int fl, idx, bad_at, done_bad;
    logic [9:0] e;
    logic eb, aborted;
    fl = (1 + DB[id] + ((PAR[id] != 0) ? 1 : 0) + STB[id]) * DIV;
    forever begin
      @(negedge clk);
      if (!rst && tx_w[id] === 1'b0) begin
        st[id][nst[id] % 64] = cyc;
        nst[id]++;
        chk($sformatf("expected_frame%0d", id), int'(expq[id].size() > 0), 1);
        e = (expq[id].size() > 0) ? expq[id].pop_front() : 10'h0;
        bad_at = -1;
        done_bad = 0;
        aborted = 1'b0;
        for (int k = 0; k < fl; k++) begin
          if (k > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          idx = k / DIV;
          if (idx == 0) eb = 1'b0;
          else if (idx <= DB[id]) eb = e[idx-1];
          else if (PAR[id] != 0 && idx == DB[id] + 1) eb = e[9];
          else eb = 1'b1;
          if ((tx_w[id] !== eb || busy_w[id] !== 1'b1) && bad_at < 0) bad_at = k;
          if (done_w[id] !== (k == fl - 1)) done_bad++;
        end
        if (!aborted) begin
          chk($sformatf("frame%0d_data%0h_first_bad_cycle", id, e[8:0]), bad_at, -1);
          chk($sformatf("frame%0d_done_errors", id), done_bad, 0);
          frames[id]++;
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);

  initial begin
    int n0, fs, k;
    rst = 1'b1;
    vld = 3'b000;
    for (int i = 0; i < 3; i++) dat[i] = '0;
    repeat (3) step();
    chk("rst_tx", int'(tx_w[0]), 1);
    chk("rst_busy", int'(busy_w[0]), 0);
    chk("rst_done", int'(done_w[0]), 0);
    chk("rst_count", int'(cnt0), 0);
    chk("rst_ready", int'(rdy[0]), 1);
    rst = 1'b0;
    step();

    // 8N1 0xA5
    push(0, 9'h0A5, 1'b0);
    vld[0] = 1'b0;
    wait_frames(0, 1);
    repeat (5) step();
    chk("busy_after_a5", int'(busy_w[0]), 0);

    // 7-bit data, even then odd parity, 2 stop bits
    push(1, 9'h041, 1'b0);
    vld[1] = 1'b0;
    push(2, 9'h041, 1'b1);
    vld[2] = 1'b0;
    wait_frames(1, 1);
    wait_frames(2, 1);

    // backpressure with depth 4
    n0 = nst[0];
    push(0, 9'h011, 1'b0);
    push(0, 9'h022, 1'b0);
    push(0, 9'h033, 1'b0);
    push(0, 9'h044, 1'b0);
    push(0, 9'h055, 1'b0);
    chk("full_count", int'(cnt0), 4);
    chk("full_ready", int'(rdy[0]), 0);
    push(0, 9'h066, 1'b0);
    vld[0] = 1'b0;
    chk("sixth_accept_cycle", last_acc, st[0][n0 % 64] + 100);
    wait_frames(0, 7);
    chk("bp_gap", st[0][(n0 + 1) % 64] - st[0][n0 % 64], 100);

    // back-to-back, second push lands on the idle pop cycle
    repeat (5) step();
    n0 = nst[0];
    push(0, 9'h000, 1'b0);
    push(0, 9'h0FF, 1'b0);
    vld[0] = 1'b0;
    chk("simul_count", int'(cnt0), 1);
    chk("simul_busy", int'(busy_w[0]), 1);
    wait_frames(0, 9);
    chk("b2b_gap", st[0][(n0 + 1) % 64] - st[0][n0 % 64], 100);

    // reset in the third data bit with two words queued
    repeat (5) step();
    n0 = nst[0];
    push(0, 9'h012, 1'b0);
    push(0, 9'h034, 1'b0);
    push(0, 9'h056, 1'b0);
    vld[0] = 1'b0;
    chk("pre_rst_count", int'(cnt0), 2);
    k = 0;
    while (!(nst[0] > n0 && cyc >= st[0][n0 % 64] + 35) && k < 2000) begin
      step();
      k++;
    end
    chk("rst_point_reached", int'(k < 2000), 1);
    rst = 1'b1;
    expq[0].delete();
    #1;
    chk("midrst_tx", int'(tx_w[0]), 1);
    chk("midrst_count", int'(cnt0), 0);
    chk("midrst_busy", int'(busy_w[0]), 0);
    step();
    step();
    rst = 1'b0;
    fs = frames[0];
    repeat (300) step();
    chk("post_rst_starts", nst[0], n0 + 1);
    chk("post_rst_tx", int'(tx_w[0]), 1);
    chk("post_rst_busy", int'(busy_w[0]), 0);
    push(0, 9'h03C, 1'b0);
    vld[0] = 1'b0;
    wait_frames(0, fs + 1);

    repeat (5) step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("done_pulses%0d", i), dones[i], frames[i]);
      chk($sformatf("queue_left%0d", i), expq[i].size(), 0);
    end
    chk("final_count1", int'(cnt1), 0);
    chk("final_count2", int'(cnt2), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
